// File: rtl/alu_sched_pkg.sv
// -----------------------------------------------------------------------------
// alu_sched_pkg
// Shared definitions for the ALU operation scheduler:
//   - ALU control codes (passed through to the ALU unchanged)
//   - scheduler FSM state encoding
//   - bit positions of the {N,Z,C,V} flag vector
// -----------------------------------------------------------------------------
package alu_sched_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } sched_state_e;

   localparam int unsigned FLAGS_W = 32'd4;
   localparam int unsigned FLAG_N  = 32'd3;
   localparam int unsigned FLAG_Z  = 32'd2;
   localparam int unsigned FLAG_C  = 32'd1;
   localparam int unsigned FLAG_V  = 32'd0;

endpackage : alu_sched_pkg

// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
// Two-way round-robin arbiter. A grant is issued only while en_i is high;
// on a tie the requester that did not win last time is chosen.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   valid_i[1:0] request vector (bit N = requester N)
//   en_i         arbitration enable (scheduler idle)
//   grant_o[1:0] one-hot grant, combinational
//   id_o         index of the granted requester
// -----------------------------------------------------------------------------
module alu_rr_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid_i,
   input  logic       en_i,
   output logic [1:0] grant_o,
   output logic       id_o
);

   logic       last_grant_q;
   logic       last_grant_d;
   logic [1:0] grant_s;
   logic       id_s;

   // Grant selection: single requester wins outright, a tie goes to !last_grant.
   always_comb begin
      grant_s = 2'b00;
      id_s    = 1'b0;
      if (en_i) begin
         case (valid_i)
            2'b01: begin
               grant_s = 2'b01;
               id_s    = 1'b0;
            end
            2'b10: begin
               grant_s = 2'b10;
               id_s    = 1'b1;
            end
            2'b11: begin
               if (last_grant_q) begin
                  grant_s = 2'b01;
                  id_s    = 1'b0;
               end else begin
                  grant_s = 2'b10;
                  id_s    = 1'b1;
               end
            end
            default: begin
               grant_s = 2'b00;
               id_s    = 1'b0;
            end
         endcase
      end else begin
         grant_s = 2'b00;
         id_s    = 1'b0;
      end
   end

   // last_grant moves only when a grant is actually issued.
   always_comb begin
      last_grant_d = last_grant_q;
      if (|grant_s) begin
         last_grant_d = id_s;
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // last_grant register; reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   assign grant_o = grant_s;
   assign id_o    = id_s;

endmodule : alu_rr_arbiter

// File: rtl/alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler
// Shares one combinational WIDTH-bit ALU between two requesters. An IDLE ->
// EXEC -> RESP sequence latches the winning command into the ALU operand
// registers, captures the ALU result one edge later and presents it on a
// response channel tagged with the requester ID.
// Optional feature macro: ALU_SCHED_FLAGS_EN adds alu_flags_i / rsp_flags_o
// and a flag capture register.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid_i/reqN_ready_o   command handshake for requester N (0/1)
//   reqN_op_i/_a_i/_b_i         ALU control code and operands
//   alu_a_o/alu_b_o/alu_ctrl_o  registered operands and control to the ALU
//   alu_result_i                combinational ALU result
//   alu_flags_i                 {N,Z,C,V} from the ALU (flags build only)
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_id_o/rsp_data_o         requester ID and captured result
//   rsp_flags_o                 captured flags (flags build only)
//   busy_o                      high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_op_scheduler
   import alu_sched_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid_i,
   output logic               req0_ready_o,
   input  logic [1:0]         req0_op_i,
   input  logic [WIDTH-1:0]   req0_a_i,
   input  logic [WIDTH-1:0]   req0_b_i,
   input  logic               req1_valid_i,
   output logic               req1_ready_o,
   input  logic [1:0]         req1_op_i,
   input  logic [WIDTH-1:0]   req1_a_i,
   input  logic [WIDTH-1:0]   req1_b_i,
   output logic [WIDTH-1:0]   alu_a_o,
   output logic [WIDTH-1:0]   alu_b_o,
   output logic [1:0]         alu_ctrl_o,
   input  logic [WIDTH-1:0]   alu_result_i,
`ifdef ALU_SCHED_FLAGS_EN
   input  logic [FLAGS_W-1:0] alu_flags_i,
   output logic [FLAGS_W-1:0] rsp_flags_o,
`endif
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic               rsp_id_o,
   output logic [WIDTH-1:0]   rsp_data_o,
   output logic               busy_o
);

   sched_state_e     state_q;
   sched_state_e     state_d;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [1:0]       alu_ctrl_q;
   logic             id_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_data_q;

   logic [1:0]       grant_s;
   logic             grant_id_s;
   logic             accept_s;
   logic [WIDTH-1:0] sel_a_s;
   logic [WIDTH-1:0] sel_b_s;
   logic [1:0]       sel_op_s;

   alu_rr_arbiter u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i ({req1_valid_i, req0_valid_i}),
      .en_i    (state_q == IDLE),
      .grant_o (grant_s),
      .id_o    (grant_id_s)
   );

   // A grant is only issued to a valid requester, so any grant is an accept.
   assign accept_s = |grant_s;

   // Payload of the granted requester.
   always_comb begin
      sel_a_s  = req0_a_i;
      sel_b_s  = req0_b_i;
      sel_op_s = req0_op_i;
      if (grant_id_s) begin
         sel_a_s  = req1_a_i;
         sel_b_s  = req1_b_i;
         sel_op_s = req1_op_i;
      end else begin
         sel_a_s  = req0_a_i;
         sel_b_s  = req0_b_i;
         sel_op_s = req0_op_i;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Command latch on accept, result capture in EXEC; everything else holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_ctrl_q <= 2'b00;
         id_q       <= 1'b0;
         rsp_id_q   <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         if ((state_q == IDLE) && accept_s) begin
            alu_a_q    <= sel_a_s;
            alu_b_q    <= sel_b_s;
            alu_ctrl_q <= sel_op_s;
            id_q       <= grant_id_s;
         end
         if (state_q == EXEC) begin
            rsp_data_q <= alu_result_i;
            rsp_id_q   <= id_q;
         end
      end
   end

`ifdef ALU_SCHED_FLAGS_EN
   logic [FLAGS_W-1:0] rsp_flags_q;

   // Flags are captured together with the result and held with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_flags_q <= '0;
      end else if (state_q == EXEC) begin
         rsp_flags_q <= alu_flags_i;
      end else begin
         rsp_flags_q <= rsp_flags_q;
      end
   end

   assign rsp_flags_o = rsp_flags_q;
`endif

   assign req0_ready_o = grant_s[0];
   assign req1_ready_o = grant_s[1];
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_ctrl_o   = alu_ctrl_q;
   assign rsp_valid_o  = (state_q == RESP);
   assign rsp_id_o     = rsp_id_q;
   assign rsp_data_o   = rsp_data_q;
   assign busy_o       = (state_q != IDLE);

endmodule : alu_op_scheduler
